// File: rtl/fetch_pkg.sv
// Shared widths, constants and the queue-entry type for the instruction-fetch stage.
package fetch_pkg;

  localparam int PC_W   = 64;
  localparam int INST_W = 32;

  // addi x0,x0,0 -- what IF/ID sees while nothing valid is queued
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and imem (slave).
interface fetch_unit_if;
  import fetch_pkg::*;

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [PC_W-1:0]   imem_req_addr;
  logic              imem_rsp_valid;
  logic [INST_W-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/fetch_queue.sv
// Depth-2 synchronous FIFO with push, pop and flush; head is read straight from storage.
module fetch_queue #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] head_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_pop;

  assign do_pop    = pop && (count != 2'd0);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (srst || flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push)
        wr_ptr <= ~wr_ptr;
      if (do_pop)
        rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, do_pop};
    end
  end

  // When full, push+pop writes the slot being vacated by the head, which becomes the tail
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order imem requests, buffers
// returned words in a 2-entry queue and restarts at the target on a redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                srst,
  input  logic                hazard,
  input  logic                redirect_valid,
  input  logic [PC_W-1:0]     redirect_pc,
  fetch_unit_if.master        imem,
  output logic                inst_valid,
  output logic [INST_W-1:0]   inst_out,
  output logic [PC_W-1:0]     pc_out
);

  logic [PC_W-1:0] fetch_pc;
  logic [1:0]      outstanding;
  logic [1:0]      outstanding_nxt;
  logic [1:0]      drop_cnt;
  logic [1:0]      occ;
  logic [2:0]      credit_used;
  logic            accept;
  logic            rsp;
  logic            push_q;
  logic            pop_q;
  logic [PC_W-1:0] rsp_pc;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;

  assign inst_valid = (occ != 2'd0);
  assign pop_q      = inst_valid && !hazard;
  assign rsp        = imem.imem_rsp_valid;

  // Counting this cycle's pop lets a 1-cycle memory sustain one fetch per cycle; the
  // outstanding check keeps the 2-deep tag queue from overflowing while stale requests drain.
  assign credit_used = {1'b0, outstanding - drop_cnt} + {1'b0, occ} - {2'b00, pop_q};
  assign imem.imem_req_valid = !srst && (credit_used < 3'd2) &&
                               ((outstanding != 2'd2) || rsp);
  assign imem.imem_req_addr  = fetch_pc;

  assign accept          = imem.imem_req_valid && imem.imem_req_ready;
  assign push_q          = rsp && (drop_cnt == 2'd0) && !redirect_valid;
  assign outstanding_nxt = outstanding + {1'b0, accept} - {1'b0, rsp};

  // Every accepted request leaves its PC here, so the tag count is the outstanding count
  fetch_queue #(.W(PC_W)) tag_q (
    .clk       (clk),
    .srst      (srst),
    .flush     (1'b0),
    .push      (accept),
    .pop       (rsp),
    .push_data (fetch_pc),
    .head_data (rsp_pc),
    .count     (outstanding)
  );

  assign push_entry = '{pc: rsp_pc, inst: imem.imem_rsp_data};

  fetch_queue #(.W($bits(fetch_entry_t))) out_q (
    .clk       (clk),
    .srst      (srst),
    .flush     (redirect_valid),
    .push      (push_q),
    .pop       (pop_q),
    .push_data (push_entry),
    .head_data (head_entry),
    .count     (occ)
  );

  // A redirect marks everything still in flight, including this cycle's accept, as stale
  always_ff @(posedge clk) begin
    if (srst) begin
      fetch_pc <= RESET_PC;
      drop_cnt <= 2'd0;
    end else if (redirect_valid) begin
      fetch_pc <= word_align(redirect_pc);
      drop_cnt <= outstanding_nxt;
    end else begin
      if (accept)
        fetch_pc <= fetch_pc + PC_W'(4);
      if (rsp && (drop_cnt != 2'd0))
        drop_cnt <= drop_cnt - 2'd1;
    end
  end

  assign inst_out = inst_valid ? head_entry.inst : NOP_INST;
  assign pc_out   = inst_valid ? head_entry.pc   : '0;

endmodule
